// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: holds the PC for the Instruction Fetch stage. It issues
// one req/ack read at a time to instruction memory and writes the fetched word
// into the IF/ID register. A one-entry skid buffer catches a word that returns
// while IF/ID is full and stalled.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   pc_cur          current PC, fed to the address generator
//   next_pc         next address chosen by the address generator
//   flush           branch taken: kill the in-flight/IF-ID word, redirect
//   stall           downstream cannot take a new IF/ID word this cycle
//   imem_req/addr   read request and word-aligned address
//   imem_ack/rdata  read data valid strobe and data
//   ifid_valid/instr/pc4  IF/ID register contents
//   align_err       one-cycle pulse when a misaligned next_pc was loaded
//   fetch_err       sticky memory-timeout flag, cleared only by rst
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc_cur,
    input  logic [31:0] next_pc,
    input  logic        flush,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        align_err,
    output logic        fetch_err
);

    localparam logic [15:0] TMO = 16'(TIMEOUT);

    // HOLD always means the skid buffer is full, so no separate skid flag.
    typedef enum logic [0:0] {ST_REQ = 1'b0, ST_HOLD = 1'b1} state_t;

    state_t      state_r, state_s;
    logic [31:0] pc_r, pc_s;
    logic        ifid_valid_r, ifid_valid_s;
    logic [31:0] ifid_instr_r, ifid_instr_s;
    logic [31:0] ifid_pc4_r, ifid_pc4_s;
    logic [31:0] skid_instr_r, skid_instr_s;
    logic [31:0] skid_pc4_r, skid_pc4_s;
    logic        redir_pend_r, redir_pend_s;
    logic [31:0] redir_pc_r, redir_pc_s;
    logic [15:0] tmo_cnt_r, tmo_cnt_s;
    logic        align_err_r, align_err_s;
    logic        fetch_err_r, fetch_err_s;
    logic        load_pc_s;
    logic [31:0] load_val_s;
    logic [31:0] pc_plus4_s;

    assign pc_plus4_s = pc_r + 32'd4;   // wraps modulo 2^32

    // Next-state and datapath selection for the fetch engine.
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        ifid_valid_s = ifid_valid_r;
        ifid_instr_s = ifid_instr_r;
        ifid_pc4_s   = ifid_pc4_r;
        skid_instr_s = skid_instr_r;
        skid_pc4_s   = skid_pc4_r;
        redir_pend_s = redir_pend_r;
        redir_pc_s   = redir_pc_r;
        tmo_cnt_s    = tmo_cnt_r;
        align_err_s  = 1'b0;
        fetch_err_s  = fetch_err_r;
        load_pc_s    = 1'b0;
        load_val_s   = pc_r;

        case (state_r)
            ST_REQ: begin
                if (imem_ack) begin
                    tmo_cnt_s = 16'd0;
                    if (flush) begin
                        // Returning word belongs to the killed path.
                        ifid_valid_s = 1'b0;
                        redir_pend_s = 1'b0;
                        load_pc_s    = 1'b1;
                        load_val_s   = next_pc;
                    end else if (redir_pend_r) begin
                        // Word fetched before an earlier flush: drop it.
                        redir_pend_s = 1'b0;
                        load_pc_s    = 1'b1;
                        load_val_s   = redir_pc_r;
                        if (!stall) begin
                            ifid_valid_s = 1'b0;
                        end else begin
                            ifid_valid_s = ifid_valid_r;
                        end
                    end else if (!ifid_valid_r || !stall) begin
                        ifid_instr_s = imem_rdata;
                        ifid_pc4_s   = pc_plus4_s;
                        ifid_valid_s = 1'b1;
                        load_pc_s    = 1'b1;
                        load_val_s   = next_pc;
                    end else begin
                        skid_instr_s = imem_rdata;
                        skid_pc4_s   = pc_plus4_s;
                        load_pc_s    = 1'b1;
                        load_val_s   = next_pc;
                        state_s      = ST_HOLD;
                    end
                end else begin
                    // Saturating timeout counter; fetch_err sets on the
                    // cycle the count reaches TIMEOUT.
                    if (tmo_cnt_r < TMO) begin
                        tmo_cnt_s = tmo_cnt_r + 16'd1;
                        if (tmo_cnt_r + 16'd1 == TMO) begin
                            fetch_err_s = 1'b1;
                        end else begin
                            fetch_err_s = fetch_err_r;
                        end
                    end else begin
                        tmo_cnt_s   = tmo_cnt_r;
                        fetch_err_s = 1'b1;
                    end
                    if (flush) begin
                        // Address must stay put until the ack; remember target.
                        ifid_valid_s = 1'b0;
                        redir_pc_s   = next_pc;
                        redir_pend_s = 1'b1;
                    end else if (!stall) begin
                        ifid_valid_s = 1'b0;
                    end else begin
                        ifid_valid_s = ifid_valid_r;
                    end
                end
            end
            ST_HOLD: begin
                if (flush) begin
                    ifid_valid_s = 1'b0;
                    load_pc_s    = 1'b1;
                    load_val_s   = next_pc;
                    state_s      = ST_REQ;
                end else if (!stall) begin
                    ifid_instr_s = skid_instr_r;
                    ifid_pc4_s   = skid_pc4_r;
                    ifid_valid_s = 1'b1;
                    state_s      = ST_REQ;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                state_s = ST_REQ;
            end
        endcase

        if (load_pc_s) begin
            pc_s        = {load_val_s[31:2], 2'b00};
            align_err_s = |load_val_s[1:0];
        end else begin
            pc_s = pc_r;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_REQ;
            pc_r         <= RESET_PC;
            ifid_valid_r <= 1'b0;
            ifid_instr_r <= 32'd0;
            ifid_pc4_r   <= 32'd0;
            skid_instr_r <= 32'd0;
            skid_pc4_r   <= 32'd0;
            redir_pend_r <= 1'b0;
            redir_pc_r   <= 32'd0;
            tmo_cnt_r    <= 16'd0;
            align_err_r  <= 1'b0;
            fetch_err_r  <= 1'b0;
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            ifid_valid_r <= ifid_valid_s;
            ifid_instr_r <= ifid_instr_s;
            ifid_pc4_r   <= ifid_pc4_s;
            skid_instr_r <= skid_instr_s;
            skid_pc4_r   <= skid_pc4_s;
            redir_pend_r <= redir_pend_s;
            redir_pc_r   <= redir_pc_s;
            tmo_cnt_r    <= tmo_cnt_s;
            align_err_r  <= align_err_s;
            fetch_err_r  <= fetch_err_s;
        end
    end

    // The request is masked while rst is high so an abandoned access never
    // appears to be issued during the reset cycle.
    assign imem_req   = (state_r == ST_REQ) && !rst;
    assign imem_addr  = pc_r;
    assign pc_cur     = pc_r;
    assign ifid_valid = ifid_valid_r;
    assign ifid_instr = ifid_instr_r;
    assign ifid_pc4   = ifid_pc4_r;
    assign align_err  = align_err_r;
    assign fetch_err  = fetch_err_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit (TIMEOUT=4). Each row drives one
// cycle's inputs and lists the outputs expected in that cycle, before its
// clock edge.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, flush, stall, imem_ack;
    logic [31:0] next_pc, imem_rdata;
    logic [31:0] pc_cur, imem_addr, ifid_instr, ifid_pc4;
    logic        imem_req, ifid_valid, align_err, fetch_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .pc_cur(pc_cur), .next_pc(next_pc),
        .flush(flush), .stall(stall), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4),
        .align_err(align_err), .fetch_err(fetch_err)
    );

    typedef struct {
        logic        r, f, s, a;
        logic [31:0] rd, np;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_v;
        logic [31:0] e_i, e_p4;
        logic        e_al, e_fe;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, f, s, a, input logic [31:0] rd, np,
                       input logic e_req, input logic [31:0] e_addr,
                       input logic e_v, input logic [31:0] e_i, e_p4,
                       input logic e_al, e_fe);
        vec_t t;
        t.r = r; t.f = f; t.s = s; t.a = a; t.rd = rd; t.np = np;
        t.e_req = e_req; t.e_addr = e_addr; t.e_v = e_v; t.e_i = e_i;
        t.e_p4 = e_p4; t.e_al = e_al; t.e_fe = e_fe;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, f, s, a, input logic [31:0] rd, np);
        @(negedge clk);
        rst = r; flush = f; stall = s; imem_ack = a; imem_rdata = rd; next_pc = np;
        #1;
    endtask

    task automatic chk_all(input int k, input logic e_req, input logic [31:0] e_addr,
                           input logic e_v, input logic [31:0] e_i, e_p4,
                           input logic e_al, e_fe);
        chk($sformatf("row%0d imem_req", k), {31'd0, imem_req}, {31'd0, e_req});
        chk($sformatf("row%0d imem_addr", k), imem_addr, e_addr);
        chk($sformatf("row%0d pc_cur", k), pc_cur, e_addr);
        chk($sformatf("row%0d ifid_valid", k), {31'd0, ifid_valid}, {31'd0, e_v});
        chk($sformatf("row%0d ifid_instr", k), ifid_instr, e_i);
        chk($sformatf("row%0d ifid_pc4", k), ifid_pc4, e_p4);
        chk($sformatf("row%0d align_err", k), {31'd0, align_err}, {31'd0, e_al});
        chk($sformatf("row%0d fetch_err", k), {31'd0, fetch_err}, {31'd0, e_fe});
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; stall = 1'b0; imem_ack = 1'b0;
        imem_rdata = 32'd0; next_pc = 32'd0;
        repeat (2) @(posedge clk);

        //   r  f  s  a  rdata          next_pc         req addr           v  instr          pc4            al fe
        add(1, 0, 0, 0, 32'h0,         32'h0,          0, 32'h0,         0, 32'h0,         32'h0,         0, 0); // reset state
        add(0, 0, 0, 1, 32'hA000_0000, 32'h4,          1, 32'h0,         0, 32'h0,         32'h0,         0, 0);
        add(0, 0, 0, 1, 32'hA000_0004, 32'h8,          1, 32'h4,         1, 32'hA000_0000, 32'h4,         0, 0);
        add(0, 0, 1, 1, 32'hA000_0008, 32'hC,          1, 32'h8,         1, 32'hA000_0004, 32'h8,         0, 0); // ack into skid
        add(0, 0, 1, 0, 32'h0,         32'h10,         0, 32'hC,         1, 32'hA000_0004, 32'h8,         0, 0); // HOLD
        add(0, 0, 1, 0, 32'h0,         32'h10,         0, 32'hC,         1, 32'hA000_0004, 32'h8,         0, 0);
        add(0, 0, 0, 0, 32'h0,         32'h10,         0, 32'hC,         1, 32'hA000_0004, 32'h8,         0, 0); // release
        add(0, 0, 0, 1, 32'hA000_000C, 32'h10,         1, 32'hC,         1, 32'hA000_0008, 32'hC,         0, 0); // skid word
        add(0, 0, 0, 0, 32'h0,         32'h14,         1, 32'h10,        1, 32'hA000_000C, 32'h10,        0, 0);
        add(0, 1, 0, 0, 32'h0,         32'h40,         1, 32'h10,        0, 32'hA000_000C, 32'h10,        0, 0); // flush, pending
        add(0, 0, 0, 0, 32'h0,         32'h99,         1, 32'h10,        0, 32'hA000_000C, 32'h10,        0, 0);
        add(0, 0, 0, 1, 32'hBAD0_BAD0, 32'h14,         1, 32'h10,        0, 32'hA000_000C, 32'h10,        0, 0); // discarded
        add(0, 0, 0, 1, 32'hB000_0040, 32'h44,         1, 32'h40,        0, 32'hA000_000C, 32'h10,        0, 0);
        add(0, 0, 1, 1, 32'hB000_0044, 32'h48,         1, 32'h44,        1, 32'hB000_0040, 32'h44,        0, 0); // into skid
        add(0, 1, 1, 0, 32'h0,         32'h103,        0, 32'h48,        1, 32'hB000_0040, 32'h44,        0, 0); // flush+stall in HOLD
        add(0, 0, 0, 1, 32'hC000_0100, 32'h104,        1, 32'h100,       0, 32'hB000_0040, 32'h44,        1, 0);
        add(0, 0, 0, 0, 32'h0,         32'h0,          1, 32'h104,       1, 32'hC000_0100, 32'h104,       0, 0); // timeout run
        add(0, 0, 0, 0, 32'h0,         32'h0,          1, 32'h104,       0, 32'hC000_0100, 32'h104,       0, 0);
        add(0, 0, 0, 0, 32'h0,         32'h0,          1, 32'h104,       0, 32'hC000_0100, 32'h104,       0, 0);
        add(0, 0, 0, 0, 32'h0,         32'h0,          1, 32'h104,       0, 32'hC000_0100, 32'h104,       0, 0);
        add(0, 0, 0, 0, 32'h0,         32'h0,          1, 32'h104,       0, 32'hC000_0100, 32'h104,       0, 1);
        add(0, 0, 0, 0, 32'h0,         32'h0,          1, 32'h104,       0, 32'hC000_0100, 32'h104,       0, 1);
        add(0, 0, 0, 1, 32'hD000_0104, 32'h108,        1, 32'h104,       0, 32'hC000_0100, 32'h104,       0, 1);
        add(0, 0, 1, 0, 32'h0,         32'h0,          1, 32'h108,       1, 32'hD000_0104, 32'h108,       0, 1);
        add(1, 0, 0, 1, 32'hDEAD_BEEF, 32'h0,          0, 32'h108,       1, 32'hD000_0104, 32'h108,       0, 1); // late ack in rst
        add(0, 0, 0, 0, 32'h0,         32'h0,          1, 32'h0,         0, 32'h0,         32'h0,         0, 0);
        add(0, 1, 0, 0, 32'h0,         32'h200,        1, 32'h0,         0, 32'h0,         32'h0,         0, 0);
        add(0, 1, 0, 0, 32'h0,         32'hFFFF_FFFC,  1, 32'h0,         0, 32'h0,         32'h0,         0, 0); // overwrite
        add(0, 0, 0, 1, 32'h1234_5678, 32'h300,        1, 32'h0,         0, 32'h0,         32'h0,         0, 0);
        add(0, 0, 0, 1, 32'hE000_0000, 32'h0,          1, 32'hFFFF_FFFC, 0, 32'h0,         32'h0,         0, 0);
        add(0, 0, 1, 0, 32'h0,         32'h0,          1, 32'h0,         1, 32'hE000_0000, 32'h0,         0, 0); // pc4 wrap
        add(0, 1, 1, 1, 32'h5555_5555, 32'h20,         1, 32'h0,         1, 32'hE000_0000, 32'h0,         0, 0); // flush+ack
        add(0, 0, 0, 0, 32'h0,         32'h0,          1, 32'h20,        0, 32'hE000_0000, 32'h0,         0, 0);

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].r, vecs[k].f, vecs[k].s, vecs[k].a, vecs[k].rd, vecs[k].np);
            chk_all(k, vecs[k].e_req, vecs[k].e_addr, vecs[k].e_v, vecs[k].e_i,
                    vecs[k].e_p4, vecs[k].e_al, vecs[k].e_fe);
        end

        // Misaligned next_pc on a normal ack: pulse lasts exactly one cycle.
        drive(0, 0, 0, 1, 32'hF000_0020, 32'h27);
        chk("seq_al ack_addr", imem_addr, 32'h20);
        drive(0, 0, 1, 0, 32'h0, 32'h0);
        chk("seq_al pc_aligned", imem_addr, 32'h24);
        chk("seq_al pulse", {31'd0, align_err}, 32'd1);
        chk("seq_al instr", ifid_instr, 32'hF000_0020);
        drive(0, 0, 1, 0, 32'h0, 32'h0);
        chk("seq_al pulse_end", {31'd0, align_err}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
